mult_booth: RTL and testbench

//  Sequential radix-2 Booth multiplier for the math unit. It is the multiply counterpart of the

---
 rtl/math_pkg.sv | 23 ++
 rtl/booth_step.sv | 29 ++
 rtl/mult_booth.sv | 118 +++++++++++
 tb/tb_mult_booth.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared math-unit definitions: FSM state encoding, default operand width,
// counter sizing and the HI/LO split of a 2*WIDTH result. Also used by the divider.
package math_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } math_state_e;

  localparam int MATH_WIDTH = 32;

  localparam int HI_MSB = 2 * MATH_WIDTH - 1;
  localparam int HI_LSB = MATH_WIDTH;
  localparam int LO_MSB = MATH_WIDTH - 1;
  localparam int LO_LSB = 0;

  // Wide enough to count WIDTH+1 iterations, the worst case of any build.
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract/hold the multiplicand on the upper half
// of the product register, then shift the whole register right arithmetically.
module booth_step #(
  parameter int W = 32,
  parameter int E = W
) (
  input  logic [2*E:0] p_i,
  input  logic [W-1:0] m_i,
  input  logic         uns_i,
  output logic [2*E:0] p_o
);

  logic [E:0] upper;
  logic [E:0] m_ext;
  logic [E:0] sum;

  // One guard bit keeps the most-negative multiplicand from overflowing the add/sub.
  always_comb begin
    upper = {p_i[2*E], p_i[2*E:E+1]};
    m_ext = {{(E + 1 - W){uns_i ? 1'b0 : m_i[W-1]}}, m_i};
    case (p_i[1:0])
      2'b01:   sum = upper + m_ext;
      2'b10:   sum = upper - m_ext;
      default: sum = upper;
    endcase
    p_o = {sum, p_i[E:1]};
  end

endmodule

// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier, HI = product[2W-1:W], LO = product[W-1:0].
// Define MULT_UNSIGNED_EN to add the Unsigned_Op port and multu semantics.
module mult_booth
  import math_pkg::*;
#(
  parameter int WIDTH = MATH_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MULT_UNSIGNED_EN
  input  logic             Unsigned_Op,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI_Out,
  output logic [WIDTH-1:0] LO_Out
);

`ifdef MULT_UNSIGNED_EN
  localparam int E = WIDTH + 1;
`else
  localparam int E = WIDTH;
`endif
  localparam int CW = cnt_width(WIDTH);

  math_state_e      state_q, state_d;
  logic [2*E:0]     p_q, p_d, p_step;
  logic [WIDTH-1:0] m_q, m_d;
  logic             uns_q, uns_d, uns_start;
  logic [CW-1:0]    cnt_q, cnt_d, n_last;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [E-1:0]     b_ext;
  logic [2*WIDTH-1:0] res;
  logic             unused_bits;

`ifdef MULT_UNSIGNED_EN
  assign uns_start = Unsigned_Op;
  // Signed mode runs one iteration fewer, so its product sits one bit higher.
  assign res         = uns_q ? p_step[2*WIDTH:1] : p_step[2*WIDTH+1:2];
  assign unused_bits = ^{p_step[2*E], p_step[0]};
`else
  assign uns_start   = 1'b0;
  assign res         = p_step[2*WIDTH:1];
  assign unused_bits = p_step[0];
`endif

  assign b_ext  = uns_start ? E'(B) : E'($signed(B));
  assign n_last = uns_q ? CW'(WIDTH) : CW'(WIDTH - 1);

  booth_step #(.W(WIDTH), .E(E)) u_step (
    .p_i   (p_q),
    .m_i   (m_q),
    .uns_i (uns_q),
    .p_o   (p_step)
  );

  // NOTE: every next-state value gets a default first so the block cannot infer a latch.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          p_d     = {{E{1'b0}}, b_ext, 1'b0};
          m_d     = A;
          uns_d   = uns_start;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == n_last) begin
          state_d      = ST_DONE;
          {hi_d, lo_d} = res;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      m_q     <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy   = (state_q == ST_RUN);
  assign Done   = (state_q == ST_DONE);
  assign HI_Out = hi_q;
  assign LO_Out = lo_q;

endmodule

// File: tb/tb_mult_booth.sv
// Scoreboard bench for mult_booth: directed operand pairs with hand-computed products;
// a negedge monitor pops the expected result whenever Done is seen.
module tb_mult_booth;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] A, B;
  logic        uns;
  logic        Busy, Done;
  logic [31:0] HI_Out, LO_Out;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  mult_booth dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .A      (A),
    .B      (B),
`ifdef MULT_UNSIGNED_EN
    .Unsigned_Op (uns),
`endif
    .Busy   (Busy),
    .Done   (Done),
    .HI_Out (HI_Out),
    .LO_Out (LO_Out)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (Reset === 1'b0 && Done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {63'b0, Done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, {32'b0, HI_Out}, {32'b0, e.hi});
        check({e.name, "_lo"}, {32'b0, LO_Out}, {32'b0, e.lo});
        check({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while ((sb.size() != 0 || Busy || Done) && n < 200);
    if (n >= 200) check("timeout_outstanding", 64'(sb.size()), 64'd0);
  endtask

  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic u, input logic [31:0] eh, input logic [31:0] el,
                       input int lat);
    exp_t e;
    wait_idle();
    A = a; B = b; uns = u; Start = 1'b1;
    e.hi = eh; e.lo = el; e.acc = cyc + 1; e.lat = lat; e.name = name;
    sb.push_back(e);
    @(negedge Clock);
    Start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; uns = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_busy", {63'b0, Busy}, 64'd0);
    check("reset_done", {63'b0, Done}, 64'd0);
    check("reset_hi", {32'b0, HI_Out}, 64'd0);
    check("reset_lo", {32'b0, LO_Out}, 64'd0);
    Reset = 1'b0;

    issue("6x2",      32'd6,          32'd2,          1'b0, 32'h00000000, 32'h0000000C, 32);
    issue("m3x7",     32'hFFFFFFFD,   32'd7,          1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 32);
    issue("minxmin",  32'h80000000,   32'h80000000,   1'b0, 32'h40000000, 32'h00000000, 32);
    issue("minx1",    32'h80000000,   32'd1,          1'b0, 32'hFFFFFFFF, 32'h80000000, 32);
    issue("m1xmin",   32'hFFFFFFFF,   32'h80000000,   1'b0, 32'h00000000, 32'h80000000, 32);
    issue("zero",     32'd0,          32'h12345678,   1'b0, 32'h00000000, 32'h00000000, 32);
    issue("maxxmax",  32'h7FFFFFFF,   32'h7FFFFFFF,   1'b0, 32'h3FFFFFFF, 32'h00000001, 32);

    // Reset in the middle of 5*5, with the previous nonzero result still on HI/LO.
    issue("rst_5x5",  32'd5,          32'd5,          1'b0, 32'h00000000, 32'h00000019, 32);
    repeat (9) @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("midrst_busy", {63'b0, Busy}, 64'd0);
    check("midrst_done", {63'b0, Done}, 64'd0);
    check("midrst_hi", {32'b0, HI_Out}, 64'd0);
    check("midrst_lo", {32'b0, LO_Out}, 64'd0);
    sb.delete();
    @(negedge Clock);
    Reset = 1'b0;
    issue("fresh_5x5", 32'd5,         32'd5,          1'b0, 32'h00000000, 32'h00000019, 32);

    // Start with new operands during RUN must be ignored; operand changes too.
    issue("9x4",      32'd9,          32'd4,          1'b0, 32'h00000000, 32'h00000024, 32);
    repeat (5) @(negedge Clock);
    A = 32'd100; B = 32'd100; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0; A = 32'd7; B = 32'd7;
    wait_idle();

    // Start held high: second accept lands N+2 cycles after the first.
    wait_idle();
    A = 32'd3; B = 32'd5; uns = 1'b0; Start = 1'b1;
    k = cyc + 1;
    e.hi = 32'd0; e.lo = 32'd15; e.lat = 32;
    e.acc = k;      e.name = "held_first";  sb.push_back(e);
    e.acc = k + 34; e.name = "held_second"; sb.push_back(e);
    repeat (35) @(negedge Clock);
    Start = 1'b0;
    wait_idle();

`ifdef MULT_UNSIGNED_EN
    issue("multu_ff", 32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'hFFFFFFFE, 32'h00000001, 33);
    issue("mult_ff",  32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'h00000000, 32'h00000001, 32);
    issue("multu_min", 32'h80000000,  32'h00000003,   1'b1, 32'h00000001, 32'h80000000, 33);
`endif

    wait_idle();
    repeat (3) @(negedge Clock);
    check("final_queue_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
